// File: rtl/mux81_rr_arbiter_pkg.sv
// Shared constants for the 8-requester round-robin arbiter around the 8:1 mux.
package mux81_rr_arbiter_pkg;

    localparam int N                = 8;
    localparam int SEL_W            = 3;
    localparam int MAX_HOLD_DEFAULT = 4;
    localparam int CNT_W_DEFAULT    = 4;

    // Arbiter FSM encoding; kept as plain constants so older netlists compare cleanly.
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    // One-hot grant vector for a requester index.
    function automatic logic [N-1:0] onehot8(input logic [SEL_W-1:0] idx);
        logic [N-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/mux81.sv
// Structural 8:1 one-bit mux: three levels of 2:1 selection driven by sel bits 0..2.
module mux81
    import mux81_rr_arbiter_pkg::*;
(
    input  logic [SEL_W-1:0] sel,
    input  logic [N-1:0]     din,
    output logic             y
);

    logic [3:0] lvl1;
    logic [1:0] lvl2;

    assign lvl1[0] = sel[0] ? din[1] : din[0];
    assign lvl1[1] = sel[0] ? din[3] : din[2];
    assign lvl1[2] = sel[0] ? din[5] : din[4];
    assign lvl1[3] = sel[0] ? din[7] : din[6];

    assign lvl2[0] = sel[1] ? lvl1[1] : lvl1[0];
    assign lvl2[1] = sel[1] ? lvl1[3] : lvl1[2];

    assign y = sel[2] ? lvl2[1] : lvl2[0];

endmodule

// File: rtl/mux81_rr_arbiter_rr_pick8.sv
// Circular priority encoder: first set bit of mask scanning start, start+1, ... (7 wraps to 0).
module rr_pick8
    import mux81_rr_arbiter_pkg::*;
(
    input  logic [N-1:0]     mask,
    input  logic [SEL_W-1:0] start,
    output logic [SEL_W-1:0] idx,
    output logic             any
);

    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    logic [SEL_W-1:0] off;

    // Rotate the mask so that bit 'start' lands at position 0.
    assign dbl = {mask, mask} >> start;
    assign rot = dbl[N-1:0];
    assign any = |mask;

    // Lowest set bit of the rotated mask is the closest requester after start.
    always_comb begin
        off = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (rot[k]) begin
                off = SEL_W'(k);
            end
        end
    end

    assign idx = start + off;

endmodule

// File: rtl/mux81_rr_arbiter.sv
// Round-robin arbiter sharing one 8:1 mux among eight requesters, with a grant-hold limit.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | no grant; gnt=0, sel keeps last grantee
//   ST_GRANT | requester sel owns the mux; hold_cnt counts cycles of ownership
module mux81_rr_arbiter
    import mux81_rr_arbiter_pkg::*;
#(
    parameter int MAX_HOLD = MAX_HOLD_DEFAULT,
    parameter int CNT_W    = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req,
    input  logic [N-1:0]     din,
    output logic [SEL_W-1:0] sel,
    output logic [N-1:0]     gnt,
    output logic             busy,
    output logic             dout,
    output logic             dout_vld
);

    localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(MAX_HOLD);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [0:0]       state, state_nxt;
    logic [SEL_W-1:0] ptr, ptr_nxt;
    logic [SEL_W-1:0] sel_nxt;
    logic [N-1:0]     gnt_nxt;
    logic [CNT_W-1:0] hold_cnt, hold_nxt;

    logic [N-1:0]     pick_mask;
    logic [SEL_W-1:0] pick_start;
    logic [SEL_W-1:0] pick_idx;
    logic             pick_any;
    logic             owner_req;
    logic             expired;
    logic             mux_y;

    // In IDLE gnt is zero and on release req[sel] is zero, so masking off the
    // current grantee is harmless there and is exactly what preemption needs.
    assign pick_mask  = req & ~gnt;
    assign pick_start = (state == ST_IDLE) ? ptr : sel + 3'd1;
    assign owner_req  = req[sel];
    assign expired    = (hold_cnt == HOLD_LIM);

    rr_pick8 u_pick (
        .mask  (pick_mask),
        .start (pick_start),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    mux81 u_mux (
        .sel (sel),
        .din (din),
        .y   (mux_y)
    );

    // Next-state logic: grant from idle, release hand-off, hold-limit preemption.
    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        sel_nxt   = sel;
        gnt_nxt   = gnt;
        hold_nxt  = hold_cnt;
        case (state)
            ST_IDLE: begin
                if (pick_any) begin
                    state_nxt = ST_GRANT;
                    sel_nxt   = pick_idx;
                    gnt_nxt   = onehot8(pick_idx);
                    hold_nxt  = CNT_ONE;
                end
            end
            ST_GRANT: begin
                if (!owner_req) begin
                    // Release takes precedence over expiry in the same cycle.
                    ptr_nxt = sel + 3'd1;
                    if (pick_any) begin
                        sel_nxt  = pick_idx;
                        gnt_nxt  = onehot8(pick_idx);
                        hold_nxt = CNT_ONE;
                    end else begin
                        state_nxt = ST_IDLE;
                        gnt_nxt   = '0;
                        hold_nxt  = '0;
                    end
                end else if (expired) begin
                    if (pick_any) begin
                        ptr_nxt  = sel + 3'd1;
                        sel_nxt  = pick_idx;
                        gnt_nxt  = onehot8(pick_idx);
                    end
                    // Either a new owner starts its window or the lone owner restarts.
                    hold_nxt = CNT_ONE;
                end else begin
                    hold_nxt = hold_cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                gnt_nxt   = '0;
                hold_nxt  = '0;
            end
        endcase
    end

    // Arbiter state and registered grant outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            ptr      <= '0;
            sel      <= '0;
            gnt      <= '0;
            hold_cnt <= '0;
        end else begin
            state    <= state_nxt;
            ptr      <= ptr_nxt;
            sel      <= sel_nxt;
            gnt      <= gnt_nxt;
            hold_cnt <= hold_nxt;
        end
    end

    // Capture the mux output whenever a grant is active this cycle; hold it otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout     <= 1'b0;
            dout_vld <= 1'b0;
        end else if (|gnt) begin
            dout     <= mux_y;
            dout_vld <= 1'b1;
        end else begin
            dout_vld <= 1'b0;
        end
    end

    assign busy = |gnt;

endmodule

// File: tb/tb_mux81_rr_arbiter.sv
// Self-checking bench: directed scenarios plus randomized traffic against a behavioural arbiter model.
module tb_mux81_rr_arbiter;

    localparam int MH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] req = 8'h00;
    logic [7:0] din = 8'h00;
    logic [2:0] sel;
    logic [7:0] gnt;
    logic       busy;
    logic       dout;
    logic       dout_vld;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    always #5 clk = ~clk;

    mux81_rr_arbiter #(.MAX_HOLD(MH), .CNT_W(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .din      (din),
        .sel      (sel),
        .gnt      (gnt),
        .busy     (busy),
        .dout     (dout),
        .dout_vld (dout_vld)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        int g;      // current grantee, -1 when idle
        int sel;    // last grantee
        int ptr;
        int hold;
    } mst_t;

    mst_t m;
    bit   m_dout;
    bit   m_vld;
    int   waitc [8];

    function automatic int pick(input logic [7:0] msk, input int start);
        for (int k = 0; k < 8; k++) begin
            if (msk[(start + k) % 8]) return (start + k) % 8;
        end
        return -1;
    endfunction

    function automatic mst_t step(input mst_t s, input logic [7:0] r);
        mst_t n;
        int w;
        logic [7:0] oth;
        n = s;
        if (s.g < 0) begin
            if (r != 0) begin
                w = pick(r, s.ptr);
                n.g = w; n.sel = w; n.hold = 1;
            end
        end else if (!r[s.g]) begin
            n.ptr = (s.g + 1) % 8;
            if (r != 0) begin
                w = pick(r, n.ptr);
                n.g = w; n.sel = w; n.hold = 1;
            end else begin
                n.g = -1; n.hold = 0;
            end
        end else if (s.hold == MH) begin
            oth = r;
            oth[s.g] = 1'b0;
            if (oth != 0) begin
                n.ptr = (s.g + 1) % 8;
                w = pick(oth, n.ptr);
                n.g = w; n.sel = w;
            end
            n.hold = 1;
        end else begin
            n.hold = s.hold + 1;
        end
        return n;
    endfunction

    function automatic logic [7:0] exp_gnt(input int g);
        logic [7:0] v;
        v = 8'h00;
        if (g >= 0) v[g] = 1'b1;
        return v;
    endfunction

    function automatic int max_wait();
        int mx;
        mx = 0;
        for (int i = 0; i < 8; i++) if (waitc[i] > mx) mx = waitc[i];
        return mx;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m      <= '{g: -1, sel: 0, ptr: 0, hold: 0};
            m_dout <= 1'b0;
            m_vld  <= 1'b0;
            for (int i = 0; i < 8; i++) waitc[i] <= 0;
        end else begin
            if (m.g >= 0) begin
                m_dout <= din[m.sel];
                m_vld  <= 1'b1;
            end else begin
                m_vld  <= 1'b0;
            end
            for (int i = 0; i < 8; i++) waitc[i] <= (req[i] && m.g != i) ? waitc[i] + 1 : 0;
            m <= step(m, req);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("gnt",        gnt,            exp_gnt(m.g));
            check("sel",        sel,            m.sel);
            check("busy",       busy,           (m.g >= 0));
            check("dout_vld",   dout_vld,       m_vld);
            check("dout",       dout,           m_dout);
            check("onehot",     $onehot0(gnt),  1);
            check("gnt_sel",    gnt[sel],       busy);
            check("starvation", (max_wait() <= 7 * MH), 1);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        // Pin the model's winner function with hand-computed cases.
        check("model_pick_wrap", pick(8'h81, 5), 7);
        check("model_pick_zero", pick(8'h41, 7), 0);
        check("model_pick_self", pick(8'h0A, 1), 1);

        #1 rst = 1'b1;
        chk_en = 1'b1;
        repeat (2) tick();
        check("rst_gnt", gnt, 8'h00);
        check("rst_sel", sel, 3'd0);
        check("rst_busy", busy, 1'b0);
        check("rst_vld", dout_vld, 1'b0);
        check("rst_dout", dout, 1'b0);
        rst = 1'b0;
        tick();

        // Reset mid-grant
        req = 8'h04;
        tick();
        check("mid_pre_gnt", gnt, 8'h04);
        check("mid_pre_sel", sel, 3'd2);
        rst = 1'b1;
        #1;
        check("mid_async_gnt", gnt, 8'h00);
        check("mid_async_sel", sel, 3'd0);
        check("mid_async_busy", busy, 1'b0);
        check("mid_async_vld", dout_vld, 1'b0);
        tick();
        rst = 1'b0;
        tick();
        check("mid_post_gnt", gnt, 8'h04);
        check("mid_post_sel", sel, 3'd2);
        req = 8'h00;
        tick();
        tick();

        // Single requester holds across expiries
        req = 8'h20;
        tick();
        check("single_sel", sel, 3'd5);
        check("single_gnt", gnt, 8'h20);
        for (int k = 0; k < 10; k++) begin
            tick();
            check("single_hold", gnt, 8'h20);
        end
        req = 8'h00;
        tick();
        check("single_drop_gnt", gnt, 8'h00);
        check("single_drop_sel", sel, 3'd5);
        tick();

        // Round-robin wrap 6,0,6,0 with MH cycles each
        req = 8'h41;
        for (int k = 0; k < 16; k++) begin
            tick();
            check("rr_wrap", gnt, (((k / MH) % 2) == 0) ? 8'h40 : 8'h01);
        end
        req = 8'h00;
        tick();
        tick();

        // Back-to-back release
        req = 8'h0A;
        tick();
        check("b2b_first", gnt, 8'h02);
        req = 8'h08;
        tick();
        check("b2b_second", gnt, 8'h08);
        check("b2b_busy", busy, 1'b1);

        // Data path through grantee 3
        din = 8'b0000_1000;
        tick();
        check("data_one", dout, 1'b1);
        check("data_one_vld", dout_vld, 1'b1);
        din = 8'h00;
        tick();
        check("data_zero", dout, 1'b0);
        check("data_zero_vld", dout_vld, 1'b1);
        req = 8'h00;
        tick();
        check("data_rel_gnt", gnt, 8'h00);
        tick();
        check("data_idle_vld", dout_vld, 1'b0);

        // Release on the expiry cycle
        req = 8'h90;
        tick();
        check("relexp_first", gnt, 8'h10);
        repeat (3) tick();
        check("relexp_hold4", gnt, 8'h10);
        req = 8'h81;
        tick();
        check("relexp_next", gnt, 8'h80);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("relexp_window", gnt, 8'h80);
        end
        tick();
        check("relexp_preempt", gnt, 8'h01);
        req = 8'h00;
        tick();
        tick();

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 8; i++) begin
                if ($urandom_range(0, 7) == 0) req[i] = ~req[i];
            end
            if ($urandom_range(0, 49) == 0) req = 8'h00;
            din = 8'($urandom);
            if ($urandom_range(0, 299) == 0) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
            end
            tick();
        end

        req = 8'h00;
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
